// File: rtl/pipe_hazard_ctrl.sv
// Hazard and shared-RAM controller for the 16-bit five-stage core: sequences PC, IF/ID
// and ID/EX around load-use stalls, taken branches and MEM-stage RAM bank accesses.
module pipe_hazard_ctrl #(
   parameter int MEM_WAIT = 2
) (
   input  logic        Clk_i,
   input  logic        Rst_i,
   input  logic [2:0]  IdRx_i,
   input  logic [2:0]  IdRy_i,
   input  logic        IdUseRx_i,
   input  logic        IdUseRy_i,
   input  logic        ExMemRead_i,
   input  logic [2:0]  ExRd_i,
   input  logic        BranchTaken_i,
   input  logic        MemReq_i,
   output logic        PcWrite_o,
   output logic        IfIdHold_o,
   output logic        IfIdRst_o,
   output logic        IdExFlush_o,
   output logic        BackStall_o,
   output logic        MemGrant_o,
   output logic [15:0] StallCnt_o
);

   typedef enum logic {RUN, MEM} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic        load_use;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign load_use = ExMemRead_i &
                     ((IdUseRx_i & (IdRx_i == ExRd_i)) | (IdUseRy_i & (IdRy_i == ExRd_i)));

   always_comb begin
      PcWrite_o   = 1'b0;
      IfIdHold_o  = 1'b0;
      IfIdRst_o   = 1'b0;
      IdExFlush_o = 1'b0;
      BackStall_o = 1'b0;
      MemGrant_o  = 1'b0;
      state_d     = state_q;
      cnt_d       = cnt_q;

      if (Rst_i) begin
         // Reset squashes the front-end and drops any grant in the same cycle.
         IfIdRst_o   = 1'b1;
         IdExFlush_o = 1'b1;
      end else begin
         unique case (state_q)
            RUN: begin
               if (MemReq_i) begin
                  // Back-end frozen, so any branch/load-use re-presents after the access.
                  MemGrant_o  = 1'b1;
                  BackStall_o = 1'b1;
                  IfIdHold_o  = 1'b1;
                  state_d     = MEM;
                  cnt_d       = 4'(MEM_WAIT - 2);
               end else if (BranchTaken_i) begin
                  PcWrite_o   = 1'b1;
                  IfIdRst_o   = 1'b1;
                  IdExFlush_o = 1'b1;
               end else if (load_use) begin
                  IfIdHold_o  = 1'b1;
                  IdExFlush_o = 1'b1;
               end else begin
                  PcWrite_o   = 1'b1;
               end
            end
            MEM: begin
               MemGrant_o = 1'b1;
               IfIdHold_o = 1'b1;
               if (cnt_q != 4'd0) begin
                  BackStall_o = 1'b1;
                  cnt_d       = cnt_q - 4'd1;
               end else begin
                  // Last grant cycle: EX advances while ID stays held, so bubble ID/EX.
                  IdExFlush_o = 1'b1;
                  state_d     = RUN;
               end
            end
            default: begin
               state_d = RUN;
               cnt_d   = 4'd0;
            end
         endcase
      end
   end

   assign stall_cnt_d = PcWrite_o ? stall_cnt_q : sat_inc(stall_cnt_q);

   always_ff @(posedge Clk_i) begin
      if (Rst_i) begin
         state_q     <= RUN;
         cnt_q       <= 4'd0;
         stall_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign StallCnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (MEM_WAIT=3 and 2) share one stimulus
// stream and are compared against a remaining-grant-cycles reference model.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       Rst = 1'b1;
   logic [2:0] IdRx = '0, IdRy = '0, ExRd = '0;
   logic       IdUseRx = 1'b0, IdUseRy = 1'b0, ExMemRead = 1'b0;
   logic       BranchTaken = 1'b0, MemReq = 1'b0;

   logic       pcw3, hold3, irst3, flush3, bs3, grant3;
   logic       pcw2, hold2, irst2, flush2, bs2, grant2;
   logic [15:0] sc3, sc2;
   logic [5:0] got3, got2;

   int checks = 0;
   int errors = 0;

   // Model: per DUT, grant cycles still to come after the current one starts, and StallCnt.
   int mw   [2] = '{3, 2};
   int left [2] = '{0, 0};
   int scm  [2] = '{0, 0};

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MEM_WAIT(3)) dut3 (
      .Clk_i(clk), .Rst_i(Rst), .IdRx_i(IdRx), .IdRy_i(IdRy), .IdUseRx_i(IdUseRx),
      .IdUseRy_i(IdUseRy), .ExMemRead_i(ExMemRead), .ExRd_i(ExRd),
      .BranchTaken_i(BranchTaken), .MemReq_i(MemReq), .PcWrite_o(pcw3),
      .IfIdHold_o(hold3), .IfIdRst_o(irst3), .IdExFlush_o(flush3),
      .BackStall_o(bs3), .MemGrant_o(grant3), .StallCnt_o(sc3));

   pipe_hazard_ctrl #(.MEM_WAIT(2)) dut2 (
      .Clk_i(clk), .Rst_i(Rst), .IdRx_i(IdRx), .IdRy_i(IdRy), .IdUseRx_i(IdUseRx),
      .IdUseRy_i(IdUseRy), .ExMemRead_i(ExMemRead), .ExRd_i(ExRd),
      .BranchTaken_i(BranchTaken), .MemReq_i(MemReq), .PcWrite_o(pcw2),
      .IfIdHold_o(hold2), .IfIdRst_o(irst2), .IdExFlush_o(flush2),
      .BackStall_o(bs2), .MemGrant_o(grant2), .StallCnt_o(sc2));

   // Output vector order: {PcWrite, IfIdHold, IfIdRst, IdExFlush, BackStall, MemGrant}
   assign got3 = {pcw3, hold3, irst3, flush3, bs3, grant3};
   assign got2 = {pcw2, hold2, irst2, flush2, bs2, grant2};

   function automatic logic load_use();
      return ExMemRead && ((IdUseRx && IdRx == ExRd) || (IdUseRy && IdRy == ExRd));
   endfunction

   function automatic logic [5:0] model_out(input int l);
      if (Rst)              return 6'b001100;
      if (l > 0)            return {3'b010, (l == 1), (l > 1), 1'b1};
      if (MemReq)           return 6'b010011;
      if (BranchTaken)      return 6'b101100;
      if (load_use())       return 6'b010100;
      return 6'b100000;
   endfunction

   task automatic tick();
      int nl [2];
      int ns [2];
      for (int d = 0; d < 2; d++) begin
         logic pcw;
         pcw = model_out(left[d])[5];
         if (Rst) begin
            nl[d] = 0;
            ns[d] = 0;
         end else begin
            ns[d] = (!pcw && scm[d] < 65535) ? scm[d] + 1 : scm[d];
            if (left[d] > 0)  nl[d] = left[d] - 1;
            else if (MemReq)  nl[d] = mw[d] - 1;
            else              nl[d] = 0;
         end
      end
      @(posedge clk);
      left = nl;
      scm  = ns;
      #1;
   endtask

   task automatic set_idle();
      Rst = 1'b0; MemReq = 1'b0; BranchTaken = 1'b0; ExMemRead = 1'b0;
      IdUseRx = 1'b0; IdUseRy = 1'b0; IdRx = 3'd0; IdRy = 3'd0; ExRd = 3'd0;
   endtask

   task automatic test_reset();
      Rst = 1'b1; MemReq = 1'b1;
      tick();
      for (int c = 0; c < 3; c++) begin
         #2;
         for (int d = 0; d < 2; d++) begin
            logic [5:0]  o;
            logic [15:0] s;
            o = (d == 0) ? got3 : got2;
            s = (d == 0) ? sc3 : sc2;
            checks++;
            if (o !== 6'b001100) begin
               errors++;
               $display("FAIL reset_outs dut%0d cyc%0d got %b exp %b", d, c, o, 6'b001100);
            end
            checks++;
            if (s !== 16'd0) begin
               errors++;
               $display("FAIL reset_stallcnt dut%0d got %0d exp 0", d, s);
            end
         end
         tick();
      end
      Rst = 1'b0;
      #2;
      for (int d = 0; d < 2; d++) begin
         logic [5:0] o;
         o = (d == 0) ? got3 : got2;
         checks++;
         if (o !== 6'b010011) begin
            errors++;
            $display("FAIL reset_release_access dut%0d got %b exp %b", d, o, 6'b010011);
         end
      end
      tick();
      MemReq = 1'b0;
      for (int c = 0; c < 4; c++) tick();
   endtask

   task automatic test_load_use();
      int s0 [2];
      set_idle();
      ExMemRead = 1'b1; ExRd = 3'd3; IdUseRy = 1'b1; IdRy = 3'd3;
      s0[0] = sc3; s0[1] = sc2;
      #2;
      for (int d = 0; d < 2; d++) begin
         logic [5:0] o;
         o = (d == 0) ? got3 : got2;
         checks++;
         if (o !== 6'b010100 || o !== model_out(left[d])) begin
            errors++;
            $display("FAIL load_use_stall dut%0d got %b exp %b", d, o, 6'b010100);
         end
      end
      tick();
      for (int d = 0; d < 2; d++) begin
         logic [15:0] s;
         s = (d == 0) ? sc3 : sc2;
         checks++;
         if (s !== 16'(s0[d] + 1) || s !== 16'(scm[d])) begin
            errors++;
            $display("FAIL load_use_cnt dut%0d got %0d exp %0d", d, s, s0[d] + 1);
         end
      end
      IdUseRy = 1'b0;
      #2;
      for (int d = 0; d < 2; d++) begin
         logic [5:0] o;
         o = (d == 0) ? got3 : got2;
         checks++;
         if (o !== 6'b100000) begin
            errors++;
            $display("FAIL load_use_nostall dut%0d got %b exp %b", d, o, 6'b100000);
         end
      end
      tick();
   endtask

   task automatic test_branch_priority();
      int s0 [2];
      set_idle();
      ExMemRead = 1'b1; ExRd = 3'd5; IdUseRx = 1'b1; IdRx = 3'd5; BranchTaken = 1'b1;
      s0[0] = sc3; s0[1] = sc2;
      #2;
      for (int d = 0; d < 2; d++) begin
         logic [5:0] o;
         o = (d == 0) ? got3 : got2;
         checks++;
         if (o !== 6'b101100) begin
            errors++;
            $display("FAIL branch_prio dut%0d got %b exp %b", d, o, 6'b101100);
         end
      end
      tick();
      for (int d = 0; d < 2; d++) begin
         logic [15:0] s;
         s = (d == 0) ? sc3 : sc2;
         checks++;
         if (s !== 16'(s0[d])) begin
            errors++;
            $display("FAIL branch_cnt dut%0d got %0d exp %0d", d, s, s0[d]);
         end
      end
   endtask

   task automatic test_mem_access();
      logic [5:0] exp3 [4] = '{6'b010011, 6'b010011, 6'b010101, 6'b100000};
      int s0;
      set_idle();
      MemReq = 1'b1;
      s0 = sc3;
      for (int c = 0; c < 4; c++) begin
         #2;
         checks++;
         if (got3 !== exp3[c]) begin
            errors++;
            $display("FAIL mem_access_w3 cyc%0d got %b exp %b", c, got3, exp3[c]);
         end
         checks++;
         if (got2 !== model_out(left[1])) begin
            errors++;
            $display("FAIL mem_access_w2 cyc%0d got %b exp %b", c, got2, model_out(left[1]));
         end
         tick();
         MemReq = 1'b0;
      end
      checks++;
      if (sc3 !== 16'(s0 + 3)) begin
         errors++;
         $display("FAIL mem_access_cnt got %0d exp %0d", sc3, s0 + 3);
      end
   endtask

   task automatic test_race();
      logic [5:0] exp2 [3] = '{6'b010011, 6'b010101, 6'b101100};
      set_idle();
      for (int c = 0; c < 4; c++) tick();
      MemReq = 1'b1; BranchTaken = 1'b1;
      ExMemRead = 1'b1; ExRd = 3'd2; IdUseRx = 1'b1; IdRx = 3'd2;
      for (int c = 0; c < 3; c++) begin
         #2;
         checks++;
         if (got2 !== exp2[c]) begin
            errors++;
            $display("FAIL race_w2 cyc%0d got %b exp %b", c, got2, exp2[c]);
         end
         checks++;
         if (got3 !== model_out(left[0])) begin
            errors++;
            $display("FAIL race_w3 cyc%0d got %b exp %b", c, got3, model_out(left[0]));
         end
         tick();
         MemReq = 1'b0;
      end
      set_idle();
      for (int c = 0; c < 4; c++) tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         Rst         = ($urandom_range(0, 39) == 0);
         MemReq      = ($urandom_range(0, 5) == 0);
         BranchTaken = ($urandom_range(0, 4) == 0);
         ExMemRead   = $urandom_range(0, 1);
         IdUseRx     = $urandom_range(0, 1);
         IdUseRy     = $urandom_range(0, 1);
         IdRx        = 3'($urandom_range(0, 3));
         IdRy        = 3'($urandom_range(0, 3));
         ExRd        = 3'($urandom_range(0, 3));
         #2;
         for (int d = 0; d < 2; d++) begin
            logic [5:0]  o;
            logic [15:0] s;
            o = (d == 0) ? got3 : got2;
            s = (d == 0) ? sc3 : sc2;
            checks++;
            if (o !== model_out(left[d]) || s !== 16'(scm[d])) begin
               errors++;
               $display("FAIL random dut%0d cyc%0d got %b/%0d exp %b/%0d", d, c, o, s,
                        model_out(left[d]), scm[d]);
            end
            checks++;
            if ((o[4] && o[3]) || (o[0] && o[5])) begin
               errors++;
               $display("FAIL invariant dut%0d cyc%0d got %b exp no hold+rst, no grant+pcw", d, c, o);
            end
         end
         tick();
      end
      set_idle();
      for (int c = 0; c < 4; c++) tick();
   endtask

   task automatic test_saturation_and_reset();
      set_idle();
      ExMemRead = 1'b1; ExRd = 3'd1; IdUseRx = 1'b1; IdRx = 3'd1;
      for (int c = 0; c < 70000; c++) tick();
      #2;
      for (int d = 0; d < 2; d++) begin
         logic [15:0] s;
         s = (d == 0) ? sc3 : sc2;
         checks++;
         if (s !== 16'hFFFF) begin
            errors++;
            $display("FAIL saturation dut%0d got %h exp ffff", d, s);
         end
      end
      set_idle();
      MemReq = 1'b1;
      tick();
      MemReq = 1'b0;
      Rst = 1'b1;
      #2;
      checks++;
      if (grant3 !== 1'b0 || grant2 !== 1'b0) begin
         errors++;
         $display("FAIL midmem_reset_grant got %b%b exp 00", grant3, grant2);
      end
      tick();
      Rst = 1'b0;
      #2;
      for (int d = 0; d < 2; d++) begin
         logic [5:0]  o;
         logic [15:0] s;
         o = (d == 0) ? got3 : got2;
         s = (d == 0) ? sc3 : sc2;
         checks++;
         if (o !== 6'b100000 || s !== 16'd0) begin
            errors++;
            $display("FAIL after_reset_run dut%0d got %b/%0d exp %b/0", d, o, s, 6'b100000);
         end
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch_priority();
      test_mem_access();
      test_race();
      test_random();
      test_saturation_and_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
